// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : btn_conditioner
//  Purpose  : Multi-channel button/switch conditioner. Each channel is
//             synchronised, polarity corrected and debounced on a shared
//             tick. It then produces press/release pulses and long-press
//             pulses, with optional auto-repeat.
//  Revision : 1.0  initial release
// ============================================================================
module btn_conditioner #(
   parameter int                  CHANNELS     = 7,
   parameter logic [CHANNELS-1:0] INVERT       = {CHANNELS{1'b0}},
   parameter int                  PRESCALE     = 25000,
   parameter int                  DB_TICKS     = 10,
   parameter int                  LONG_TICKS   = 1000,
   parameter int                  REPEAT_TICKS = 0
) (
   input  logic                clk_25mhz,
   input  logic                rstn,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] btn_level,
   output logic [CHANNELS-1:0] btn_press,
   output logic [CHANNELS-1:0] btn_release,
   output logic [CHANNELS-1:0] btn_long,
   output logic                tick
);

   // -------------------------------------------------------------------------
   // Derived widths and compare constants
   // -------------------------------------------------------------------------
   localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DW   = $clog2(DB_TICKS + 1);
   localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [PW-1:0] c_ps_last   = PW'(PRESCALE - 1);
   localparam logic [DW-1:0] c_db_last   = DW'(DB_TICKS - 1);
   localparam logic [HW-1:0] c_long      = HW'(LONG_TICKS);
   localparam logic [HW-1:0] c_repeat    = HW'(REPEAT_TICKS);
   localparam bit            c_repeat_en = (REPEAT_TICKS > 0);

   // -------------------------------------------------------------------------
   // Shared prescaler
   // -------------------------------------------------------------------------
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          tick_q, tick_d;

   // Next prescaler count; the tick is registered in the wrap cycle.
   always_comb begin
      pcnt_d = pcnt_q + PW'(1);
      tick_d = 1'b0;
      if (pcnt_q == c_ps_last) begin
         pcnt_d = '0;
         tick_d = 1'b1;
      end
   end

   // Prescaler counter and tick register.
   always_ff @(posedge clk_25mhz or negedge rstn) begin
      if (!rstn) begin
         pcnt_q <= '0;
         tick_q <= 1'b0;
      end else begin
         pcnt_q <= pcnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

   // -------------------------------------------------------------------------
   // Two-flop synchroniser and polarity correction
   // -------------------------------------------------------------------------
   logic [CHANNELS-1:0] s1_q;
   logic [CHANNELS-1:0] s2_q;
   logic [CHANNELS-1:0] synced;

   // Bring the asynchronous pins into the clock domain.
   always_ff @(posedge clk_25mhz or negedge rstn) begin
      if (!rstn) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= btn_in;
         s2_q <= s1_q;
      end
   end

   // Active-low pins are flipped so that 1 always means "pressed".
   assign synced = s2_q ^ INVERT;

   // -------------------------------------------------------------------------
   // Per-channel debounce, edge pulses and hold timing
   // -------------------------------------------------------------------------
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [DW-1:0] dcnt_q, dcnt_d;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;
      logic [HW-1:0] hcnt_q, hcnt_d;
      logic [HW-1:0] hcnt_inc;
      logic          longed_q, longed_d;
      logic          long_q, long_d;

      // Debounce. Any agreeing sample restarts the window. DB_TICKS
      // consecutive disagreeing ticks flip the level. The edge pulse is
      // produced together with the flip, so it lines up with the new level.
      always_comb begin
         dcnt_d  = dcnt_q;
         level_d = level_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
         if (synced[i] == level_q) begin
            dcnt_d = '0;
         end else if (tick_q) begin
            if (dcnt_q == c_db_last) begin
               level_d = synced[i];
               dcnt_d  = '0;
               press_d = synced[i];
               rel_d   = ~synced[i];
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
      end

      // Hold timing. The counter restarts on release and in the press cycle.
      // The first pulse comes at LONG_TICKS, then every REPEAT_TICKS (if
      // enabled). Otherwise the counter parks until release.
      always_comb begin
         hcnt_inc = hcnt_q + HW'(1);
         hcnt_d   = hcnt_q;
         longed_d = longed_q;
         long_d   = 1'b0;
         if (!level_q || press_q) begin
            hcnt_d   = '0;
            longed_d = 1'b0;
         end else if (tick_q) begin
            if (!longed_q) begin
               if (hcnt_inc == c_long) begin
                  long_d   = 1'b1;
                  longed_d = 1'b1;
                  hcnt_d   = '0;
               end else begin
                  hcnt_d = hcnt_inc;
               end
            end else if (c_repeat_en) begin
               if (hcnt_inc == c_repeat) begin
                  long_d = 1'b1;
                  hcnt_d = '0;
               end else begin
                  hcnt_d = hcnt_inc;
               end
            end
         end
      end

      // Per-channel state registers.
      always_ff @(posedge clk_25mhz or negedge rstn) begin
         if (!rstn) begin
            dcnt_q   <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            hcnt_q   <= '0;
            longed_q <= 1'b0;
            long_q   <= 1'b0;
         end else begin
            dcnt_q   <= dcnt_d;
            level_q  <= level_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            hcnt_q   <= hcnt_d;
            longed_q <= longed_d;
            long_q   <= long_d;
         end
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = rel_q;
      assign btn_long[i]    = long_q;
   end

endmodule
`default_nettype wire
